// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss/fill handlers (I-cache and D-cache).
// Block geometry: 16-byte blocks made of 8 words of 16 bits.
package wisc_cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam int BLOCK_OFFSET_W  = 4;
  localparam int WORD_IDX_W      = 3;

  // Fill controller state encoding
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    TAG   = 2'b11
  } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word index counter for the fill controller: synchronous clear, increment
// enable, and a wrap flag that is high on the increment leaving MAX_VAL.
module fill_counter
  import wisc_cache_pkg::*;
#(
  parameter int MAX_VAL = WORDS_PER_BLOCK - 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [WORD_IDX_W-1:0] count,
  output logic                  wrap
);

  logic [WORD_IDX_W-1:0] count_r;

  // Wrap flag: this increment takes the counter past its last value
  always_comb begin
    wrap = 1'b0;
    if (inc && !clr && (count_r == WORD_IDX_W'(MAX_VAL))) begin
      wrap = 1'b1;
    end else begin
      wrap = 1'b0;
    end
  end

  // Counter register: clear has priority over increment
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {WORD_IDX_W{1'b0}};
    end else if (clr) begin
      count_r <= {WORD_IDX_W{1'b0}};
    end else if (inc) begin
      count_r <= wrap ? {WORD_IDX_W{1'b0}} : count_r + WORD_IDX_W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss handler: on a miss, stalls the pipeline, issues 8 pipelined word
// reads to main memory, writes each returned word into the data array and
// writes the tag once the last word has arrived.
// Optional build macro CACHE_FILL_PERF_EN adds saturating miss/stall counters.
module cache_fill_fsm
  import wisc_cache_pkg::*;
#(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_detected,
  input  logic [ADDR_W-1:0]     miss_address,
  input  logic                  memory_data_valid,
  input  logic [DATA_W-1:0]     memory_data,
  output logic                  fsm_busy,
  output logic                  mem_rd_en,
  output logic [ADDR_W-1:0]     memory_address,
  output logic                  write_data_array,
  output logic [WORD_IDX_W-1:0] word_offset,
  output logic [DATA_W-1:0]     fill_data,
  output logic                  write_tag_array,
  output logic [ADDR_W-1:0]     fill_base
`ifdef CACHE_FILL_PERF_EN
  ,
  output logic [15:0]           miss_count,
  output logic [15:0]           stall_cycles
`endif
);

  fill_state_t           state_r;
  logic [ADDR_W-1:0]     fill_base_r;
  logic [WORD_IDX_W-1:0] iss_cnt_s;
  logic [WORD_IDX_W-1:0] rcv_cnt_s;
  logic                  iss_wrap_s;
  logic                  rcv_wrap_s;
  logic                  start_s;
  logic                  iss_inc_s;
  logic                  rcv_inc_s;
  logic                  unused_miss_lsb_s;

  // Byte offset within the block plays no part in a block fill
  assign unused_miss_lsb_s = ^miss_address[BLOCK_OFFSET_W-1:0];

  // Counter control: start clears both, issue/receive advance them
  always_comb begin
    start_s   = 1'b0;
    iss_inc_s = 1'b0;
    rcv_inc_s = 1'b0;
    case (state_r)
      IDLE:    start_s   = miss_detected;
      ISSUE: begin
        iss_inc_s = 1'b1;
        rcv_inc_s = memory_data_valid;
      end
      DRAIN:   rcv_inc_s = memory_data_valid;
      TAG:     rcv_inc_s = 1'b0;
      default: rcv_inc_s = 1'b0;
    endcase
  end

  fill_counter #(.MAX_VAL(WORDS_PER_BLOCK - 1)) u_iss_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_s),
    .inc   (iss_inc_s),
    .count (iss_cnt_s),
    .wrap  (iss_wrap_s)
  );

  fill_counter #(.MAX_VAL(WORDS_PER_BLOCK - 1)) u_rcv_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_s),
    .inc   (rcv_inc_s),
    .count (rcv_cnt_s),
    .wrap  (rcv_wrap_s)
  );

  // Fill sequencing and block base latch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      fill_base_r <= {ADDR_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (miss_detected) begin
            fill_base_r <= {miss_address[ADDR_W-1:BLOCK_OFFSET_W], {BLOCK_OFFSET_W{1'b0}}};
            state_r     <= ISSUE;
          end else begin
            state_r     <= IDLE;
          end
        end
        ISSUE: begin
          // A last word arriving while still issuing goes straight to the tag write
          if (rcv_wrap_s) begin
            state_r <= TAG;
          end else if (iss_wrap_s) begin
            state_r <= DRAIN;
          end else begin
            state_r <= ISSUE;
          end
        end
        DRAIN: begin
          if (rcv_wrap_s) begin
            state_r <= TAG;
          end else begin
            state_r <= DRAIN;
          end
        end
        TAG:     state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
    end
  end

  // Output decode; busy in IDLE follows the miss so the access stalls at once
  always_comb begin
    fsm_busy         = (state_r != IDLE) || miss_detected;
    mem_rd_en        = (state_r == ISSUE);
    write_tag_array  = (state_r == TAG);
    write_data_array = rcv_inc_s;
    if (state_r == ISSUE) begin
      memory_address = {fill_base_r[ADDR_W-1:BLOCK_OFFSET_W], iss_cnt_s, 1'b0};
    end else begin
      memory_address = {ADDR_W{1'b0}};
    end
    if (rcv_inc_s) begin
      word_offset = rcv_cnt_s;
      fill_data   = memory_data;
    end else begin
      word_offset = {WORD_IDX_W{1'b0}};
      fill_data   = {DATA_W{1'b0}};
    end
  end

  assign fill_base = fill_base_r;

`ifdef CACHE_FILL_PERF_EN
  logic [15:0] miss_count_r;
  logic [15:0] stall_cycles_r;

  // Saturating fill and stall counters
  always_ff @(posedge clk) begin
    if (rst) begin
      miss_count_r   <= 16'h0000;
      stall_cycles_r <= 16'h0000;
    end else begin
      if (start_s && (miss_count_r != 16'hFFFF)) begin
        miss_count_r <= miss_count_r + 16'h0001;
      end else begin
        miss_count_r <= miss_count_r;
      end
      if (fsm_busy && (stall_cycles_r != 16'hFFFF)) begin
        stall_cycles_r <= stall_cycles_r + 16'h0001;
      end else begin
        stall_cycles_r <= stall_cycles_r;
      end
    end
  end

  assign miss_count   = miss_count_r;
  assign stall_cycles = stall_cycles_r;
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
